// File: rtl/parking_gate_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// parking_gate_ctrl
//
// Sequencing and arbitration controller for a four-spot parking lot. It owns
// the spot occupancy register and shares a single gate mechanism between the
// entry and exit lanes. Arriving cars get the lowest free spot. Occupancy
// changes are committed only when the gate sensor reports that the car has
// passed.
//
// Optional feature macro: PARK_TIMEOUT_EN
//   When it is defined, an open gate auto-closes after TIMEOUT cycles without
//   car_passed. When it is undefined, there is no timer and timeout is tied 0.
//
// Parameters
//   TIMEOUT        cycles a gate may stay open without a pass (2..255)
//   INIT_OCC       occupancy loaded on reset
//
// Ports
//   clk            rising-edge clock
//   rst            synchronous active-high reset
//   entry_req      level: car waiting at the entry lane
//   exit_req       level: car waiting at the exit lane
//   exit_spot      spot index of the exiting car, valid with exit_req
//   car_passed     pulse: car cleared the currently open gate
//   entry_open     entry gate open
//   exit_open      exit gate open
//   assigned_spot  spot given to the entering car, valid while entry_open
//   occupancy      bit i set = spot i occupied
//   free_cnt       number of free spots, 0..4
//   full           all four spots occupied
//   exit_err       pulse: exit requested for an empty spot
//   timeout        pulse: gate auto-closed without a pass
// ---------------------------------------------------------------------------
module parking_gate_ctrl #(
  parameter int unsigned TIMEOUT  = 16,
  parameter logic [3:0]  INIT_OCC = 4'b0000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       entry_req,
  input  logic       exit_req,
  input  logic [1:0] exit_spot,
  input  logic       car_passed,
  output logic       entry_open,
  output logic       exit_open,
  output logic [1:0] assigned_spot,
  output logic [3:0] occupancy,
  output logic [2:0] free_cnt,
  output logic       full,
  output logic       exit_err,
  output logic       timeout
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ENTRY = 2'd1,
    ST_EXIT  = 2'd2
  } state_t;

  state_t     r_state, w_state_next;
  logic [3:0] r_occ, w_occ_next;
  logic [1:0] r_assigned_spot, w_assigned_spot_next;
  logic [1:0] r_exit_spot, w_exit_spot_next;
  logic       r_last_exit, w_last_exit_next;  // 1: the exit lane was served last
  logic       r_exit_err, w_exit_err_next;

  logic       w_full;
  logic       w_entry_elig;
  logic       w_exit_elig;
  logic       w_exit_bad;
  logic       w_grant_entry;
  logic       w_grant_exit;
  logic       w_expire;
  logic [1:0] w_lowest_free;

  assign w_full       = (r_occ == 4'b1111);
  assign w_entry_elig = entry_req && !w_full;
  assign w_exit_elig  = exit_req && r_occ[exit_spot];
  assign w_exit_bad   = exit_req && !r_occ[exit_spot];

  // Round-robin arbitration: on a tie, the lane that was not served last
  // wins.
  assign w_grant_entry = w_entry_elig && (!w_exit_elig || r_last_exit);
  assign w_grant_exit  = w_exit_elig && !w_grant_entry;

  // Find the lowest free spot. The loop scans downward, so the last hit it
  // records is the lowest index.
  always_comb begin
    w_lowest_free = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!r_occ[i]) begin
        w_lowest_free = 2'(i);
      end
    end
  end

`ifdef PARK_TIMEOUT_EN
  logic [7:0] r_timer;

  // The timer is held at zero while the FSM is in IDLE. The first open cycle
  // therefore always sees zero, and the timer counts up from there.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_timer <= 8'd0;
    end else if (r_state == ST_IDLE) begin
      r_timer <= 8'd0;
    end else begin
      r_timer <= r_timer + 8'd1;
    end
  end

  // A pass in the expiry cycle takes priority over the auto-close.
  assign w_expire = (r_state != ST_IDLE) && (r_timer == 8'(TIMEOUT - 1)) && !car_passed;
`else
  assign w_expire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= ST_IDLE;
      r_occ           <= INIT_OCC;
      r_assigned_spot <= 2'd0;
      r_exit_spot     <= 2'd0;
      r_last_exit     <= 1'b1;
      r_exit_err      <= 1'b0;
    end else begin
      r_state         <= w_state_next;
      r_occ           <= w_occ_next;
      r_assigned_spot <= w_assigned_spot_next;
      r_exit_spot     <= w_exit_spot_next;
      r_last_exit     <= w_last_exit_next;
      r_exit_err      <= w_exit_err_next;
    end
  end

  always_comb begin
    w_state_next         = r_state;
    w_occ_next           = r_occ;
    w_assigned_spot_next = r_assigned_spot;
    w_exit_spot_next     = r_exit_spot;
    w_last_exit_next     = r_last_exit;
    w_exit_err_next      = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        // A bad exit request never blocks an eligible entry.
        w_exit_err_next = w_exit_bad;
        if (w_grant_entry) begin
          w_assigned_spot_next = w_lowest_free;
          w_last_exit_next     = 1'b0;
          w_state_next         = ST_ENTRY;
        end else if (w_grant_exit) begin
          w_exit_spot_next = exit_spot;
          w_last_exit_next = 1'b1;
          w_state_next     = ST_EXIT;
        end
      end
      ST_ENTRY: begin
        if (car_passed) begin
          w_occ_next   = r_occ | (4'b0001 << r_assigned_spot);
          w_state_next = ST_IDLE;
        end else if (w_expire) begin
          w_state_next = ST_IDLE;
        end
      end
      ST_EXIT: begin
        if (car_passed) begin
          w_occ_next   = r_occ & ~(4'b0001 << r_exit_spot);
          w_state_next = ST_IDLE;
        end else if (w_expire) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  assign entry_open    = (r_state == ST_ENTRY);
  assign exit_open     = (r_state == ST_EXIT);
  assign assigned_spot = r_assigned_spot;
  assign occupancy     = r_occ;
  assign full          = w_full;
  assign free_cnt      = {2'b00, ~r_occ[0]} + {2'b00, ~r_occ[1]}
                       + {2'b00, ~r_occ[2]} + {2'b00, ~r_occ[3]};
  assign exit_err      = r_exit_err;
  assign timeout       = w_expire;

endmodule

// File: tb/tb_parking_gate_ctrl.sv
`timescale 1ns/1ps
module tb_parking_gate_ctrl;

`ifdef PARK_TIMEOUT_EN
  localparam int unsigned TB_TIMEOUT = 4;
  localparam bit          TO_EN      = 1'b1;
`else
  localparam int unsigned TB_TIMEOUT = 16;
  localparam bit          TO_EN      = 1'b0;
`endif
  localparam logic [3:0] TB_INIT = 4'b0000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       entry_req = 1'b0;
  logic       exit_req = 1'b0;
  logic [1:0] exit_spot = 2'd0;
  logic       car_passed = 1'b0;
  logic       entry_open, exit_open, full, exit_err, timeout;
  logic [1:0] assigned_spot;
  logic [3:0] occupancy;
  logic [2:0] free_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model: the gate is one of {closed, entry, exit}.
  int         m_gate = 0;          // 0 closed, 1 entry open, 2 exit open
  logic [3:0] m_occ = TB_INIT;
  logic [1:0] m_asg = 2'd0;
  logic [1:0] m_xspot = 2'd0;
  bit         m_last_exit = 1'b1;
  bit         m_err = 1'b0;
  int         m_open_cycles = 0;   // open cycles already elapsed

  parking_gate_ctrl #(.TIMEOUT(TB_TIMEOUT), .INIT_OCC(TB_INIT)) dut (
    .clk(clk), .rst(rst), .entry_req(entry_req), .exit_req(exit_req),
    .exit_spot(exit_spot), .car_passed(car_passed), .entry_open(entry_open),
    .exit_open(exit_open), .assigned_spot(assigned_spot), .occupancy(occupancy),
    .free_cnt(free_cnt), .full(full), .exit_err(exit_err), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Advance the model by one clock edge, using the inputs currently applied.
  task automatic model_step();
    bit ent_ok, ex_ok;
    int low;
    if (rst) begin
      m_gate = 0; m_occ = TB_INIT; m_asg = 2'd0; m_last_exit = 1'b1;
      m_err = 1'b0; m_open_cycles = 0;
      return;
    end
    m_err = 1'b0;
    if (m_gate == 0) begin
      ent_ok = entry_req && ($countones(m_occ) < 4);
      ex_ok  = exit_req && m_occ[exit_spot];
      m_err  = exit_req && !m_occ[exit_spot];
      if (ent_ok && (!ex_ok || m_last_exit)) begin
        low = 0;
        while (m_occ[low]) low++;
        m_asg = 2'(low); m_gate = 1; m_last_exit = 1'b0; m_open_cycles = 0;
      end else if (ex_ok) begin
        m_xspot = exit_spot; m_gate = 2; m_last_exit = 1'b1; m_open_cycles = 0;
      end
    end else if (car_passed) begin
      if (m_gate == 1) m_occ[m_asg] = 1'b1;
      else             m_occ[m_xspot] = 1'b0;
      m_gate = 0;
    end else if (TO_EN && (m_open_cycles + 1 == int'(TB_TIMEOUT))) begin
      m_gate = 0;
    end else begin
      m_open_cycles++;
    end
  endtask

  // Apply inputs, take one edge and sample 1 ns later. The pulse inputs are
  // dropped once the edge has consumed them.
  task automatic tick(input bit er, input bit xr, input logic [1:0] xs,
                      input bit cp, input bit r);
    entry_req = er; exit_req = xr; exit_spot = xs; car_passed = cp; rst = r;
    @(posedge clk);
    model_step();
    #1;
    car_passed = 1'b0; rst = 1'b0;
  endtask

  task automatic test_reset();
    tick(0, 0, 0, 0, 1);
    checks++;
    if ({entry_open, exit_open, assigned_spot, occupancy, free_cnt, full, exit_err, timeout}
        !== {1'b0, 1'b0, 2'd0, TB_INIT, 3'd4, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_values: got eo=%b xo=%b as=%0d occ=%b free=%0d full=%b err=%b to=%b want 0 0 0 0000 4 0 0 0",
               entry_open, exit_open, assigned_spot, occupancy, free_cnt, full, exit_err, timeout);
    end
    $display("test_reset done");
  endtask

  task automatic test_fill();
    for (int k = 0; k < 4; k++) begin
      tick(1, 0, 0, 0, 0);
      checks++;
      if (entry_open !== 1'b1 || assigned_spot !== 2'(k)) begin
        errors++;
        $display("FAIL fill_grant[%0d]: got open=%b spot=%0d want 1 %0d", k, entry_open, assigned_spot, k);
      end
      tick(1, 0, 0, 1, 0);
      checks++;
      if (entry_open !== 1'b0 || free_cnt !== 3'(3 - k) || occupancy[k] !== 1'b1) begin
        errors++;
        $display("FAIL fill_pass[%0d]: got open=%b free=%0d occ=%b want 0 %0d bit%0d=1",
                 k, entry_open, free_cnt, occupancy, 3 - k, k);
      end
    end
    checks++;
    if (full !== 1'b1 || occupancy !== 4'b1111) begin
      errors++;
      $display("FAIL fill_full: got full=%b occ=%b want 1 1111", full, occupancy);
    end
    tick(1, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0);
    checks++;
    if (entry_open !== 1'b0 || exit_open !== 1'b0) begin
      errors++;
      $display("FAIL full_no_grant: got eo=%b xo=%b want 0 0", entry_open, exit_open);
    end
    $display("test_fill done");
  endtask

  // Starts from 1111. Spots 0 and 2 leave, then an entry/exit tie is
  // resolved in favour of entry, and the exit follows it.
  task automatic test_round_robin();
    tick(0, 1, 0, 0, 0);
    tick(0, 0, 0, 1, 0);
    tick(0, 1, 2, 0, 0);
    tick(0, 0, 0, 1, 0);
    checks++;
    if (occupancy !== 4'b1010 || exit_open !== 1'b0) begin
      errors++;
      $display("FAIL rr_setup: got occ=%b xo=%b want 1010 0", occupancy, exit_open);
    end
    tick(1, 1, 1, 0, 0);
    checks++;
    if (entry_open !== 1'b1 || exit_open !== 1'b0 || assigned_spot !== 2'd0) begin
      errors++;
      $display("FAIL rr_entry_first: got eo=%b xo=%b spot=%0d want 1 0 0", entry_open, exit_open, assigned_spot);
    end
    tick(1, 1, 1, 1, 0);
    checks++;
    if (entry_open !== 1'b0 || occupancy !== 4'b1011) begin
      errors++;
      $display("FAIL rr_entry_pass: got eo=%b occ=%b want 0 1011", entry_open, occupancy);
    end
    tick(1, 1, 1, 0, 0);
    checks++;
    if (exit_open !== 1'b1 || entry_open !== 1'b0) begin
      errors++;
      $display("FAIL rr_exit_second: got xo=%b eo=%b want 1 0", exit_open, entry_open);
    end
    tick(0, 0, 1, 1, 0);
    checks++;
    if (occupancy !== 4'b1001 || exit_open !== 1'b0) begin
      errors++;
      $display("FAIL rr_final: got occ=%b xo=%b want 1001 0", occupancy, exit_open);
    end
    $display("test_round_robin done");
  endtask

  task automatic test_exit_err();
    tick(0, 0, 0, 0, 1);
    tick(1, 0, 0, 0, 0);
    tick(0, 0, 0, 1, 0);
    tick(0, 1, 2, 0, 0);
    checks++;
    if (exit_err !== 1'b1 || exit_open !== 1'b0 || entry_open !== 1'b0 || occupancy !== 4'b0001) begin
      errors++;
      $display("FAIL exit_err_pulse: got err=%b xo=%b eo=%b occ=%b want 1 0 0 0001",
               exit_err, exit_open, entry_open, occupancy);
    end
    tick(0, 0, 2, 0, 0);
    checks++;
    if (exit_err !== 1'b0) begin
      errors++;
      $display("FAIL exit_err_clear: got %b want 0", exit_err);
    end
    tick(1, 1, 2, 0, 0);
    checks++;
    if (exit_err !== 1'b1 || entry_open !== 1'b1 || assigned_spot !== 2'd1) begin
      errors++;
      $display("FAIL exit_err_with_entry: got err=%b eo=%b spot=%0d want 1 1 1", exit_err, entry_open, assigned_spot);
    end
    $display("test_exit_err done");
  endtask

  task automatic test_reset_mid_open();
    tick(0, 0, 0, 0, 1);
    tick(1, 0, 0, 0, 0);
    tick(1, 0, 0, 1, 0);
    tick(1, 0, 0, 0, 0);
    checks++;
    if (entry_open !== 1'b1 || assigned_spot !== 2'd1) begin
      errors++;
      $display("FAIL mid_open_setup: got eo=%b spot=%0d want 1 1", entry_open, assigned_spot);
    end
    tick(0, 0, 0, 1, 1);
    checks++;
    if (entry_open !== 1'b0 || occupancy !== TB_INIT || assigned_spot !== 2'd0) begin
      errors++;
      $display("FAIL mid_open_reset: got eo=%b occ=%b spot=%0d want 0 %b 0", entry_open, occupancy, assigned_spot, TB_INIT);
    end
    tick(1, 0, 0, 0, 0);
    checks++;
    if (entry_open !== 1'b1 || assigned_spot !== 2'd0) begin
      errors++;
      $display("FAIL mid_open_idle: got eo=%b spot=%0d want 1 0", entry_open, assigned_spot);
    end
    $display("test_reset_mid_open done");
  endtask

  task automatic test_fast_pass();
    tick(0, 0, 0, 0, 1);
    tick(1, 0, 0, 0, 0);
    checks++;
    if (entry_open !== 1'b1 || occupancy !== 4'b0000) begin
      errors++;
      $display("FAIL fast_open: got eo=%b occ=%b want 1 0000", entry_open, occupancy);
    end
    tick(0, 0, 0, 1, 0);
    checks++;
    if (entry_open !== 1'b0 || occupancy !== 4'b0001 || free_cnt !== 3'd3) begin
      errors++;
      $display("FAIL fast_closed: got eo=%b occ=%b free=%0d want 0 0001 3", entry_open, occupancy, free_cnt);
    end
    $display("test_fast_pass done");
  endtask

  task automatic test_timeout();
    tick(0, 0, 0, 0, 1);
    tick(0, 0, 0, 0, 0);
    tick(0, 0, 0, 1, 0);
    tick(0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0);
    entry_req = 1'b0;
`ifdef PARK_TIMEOUT_EN
    for (int c = 1; c <= int'(TB_TIMEOUT); c++) begin
      checks++;
      if (entry_open !== 1'b1 || timeout !== (c == int'(TB_TIMEOUT))) begin
        errors++;
        $display("FAIL timeout_cycle[%0d]: got eo=%b to=%b want 1 %b", c, entry_open, timeout, c == int'(TB_TIMEOUT));
      end
      tick(0, 0, 0, 0, 0);
    end
    checks++;
    if (entry_open !== 1'b0 || timeout !== 1'b0 || occupancy !== 4'b0000) begin
      errors++;
      $display("FAIL timeout_closed: got eo=%b to=%b occ=%b want 0 0 0000", entry_open, timeout, occupancy);
    end
`else
    for (int c = 0; c < 100; c++) begin
      checks++;
      if (timeout !== 1'b0) begin
        errors++;
        $display("FAIL no_timeout_pulse[%0d]: got %b want 0", c, timeout);
      end
      tick(0, 0, 0, 0, 0);
    end
    checks++;
    if (entry_open !== 1'b1 || occupancy !== 4'b0000) begin
      errors++;
      $display("FAIL no_timeout_open: got eo=%b occ=%b want 1 0000", entry_open, occupancy);
    end
`endif
    $display("test_timeout done");
  endtask

  task automatic test_random();
    logic [12:0] got, want;
    tick(0, 0, 0, 0, 1);
    for (int n = 0; n < 600; n++) begin
      tick(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 60) == 0));
      got  = {entry_open, exit_open, assigned_spot, occupancy, free_cnt, full, exit_err, timeout};
      want = {m_gate == 1, m_gate == 2, m_asg, m_occ, 3'(4 - $countones(m_occ)),
              m_occ == 4'b1111, m_err,
              TO_EN && (m_gate != 0) && (m_open_cycles + 1 == int'(TB_TIMEOUT))};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL random[%0d]: got eo,xo,as,occ,free,full,err,to=%b want %b", n, got, want);
      end
    end
    $display("test_random done");
  endtask

  initial begin
    test_reset();
    test_fill();
    test_round_robin();
    test_exit_err();
    test_reset_mid_open();
    test_fast_pass();
    test_timeout();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
